// File: rtl/tc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tc_pkg
//  Purpose  : Shared defaults and types for the tensor-core operand stager.
//  Revision : 1.0 - initial release
// ============================================================================
package tc_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_SIZE   = 8;
   localparam int DEF_KDEPTH = 4;

   // One packed k-slice at the default geometry
   typedef logic [DEF_SIZE*DEF_WIDTH-1:0] slice_t;

   // Read-side burst FSM
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } stager_state_e;

endpackage
`default_nettype wire

// File: rtl/tc_tile_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tc_tile_buf
//  Purpose  : One tile bank of KDEPTH A/B slice slots. A write to slot n with
//             zero_fill set also clears every slot above n, so a short tile
//             replays zeros instead of stale data. Asynchronous read port.
//  Revision : 1.0 - initial release
// ============================================================================
module tc_tile_buf
   import tc_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int SIZE   = DEF_SIZE,
   parameter int KDEPTH = DEF_KDEPTH
) (
   input  logic                        clk,
   input  logic                        wr_en,
   input  logic [$clog2(KDEPTH)-1:0]   wr_idx,
   input  logic [SIZE*WIDTH-1:0]       wr_a,
   input  logic [SIZE*WIDTH-1:0]       wr_b,
   input  logic                        zero_fill,
   input  logic [$clog2(KDEPTH)-1:0]   rd_idx,
   output logic [SIZE*WIDTH-1:0]       rd_a,
   output logic [SIZE*WIDTH-1:0]       rd_b
);

   localparam int SW = SIZE * WIDTH;
   localparam int KW = $clog2(KDEPTH);

   logic [SW-1:0] a_mem [KDEPTH];
   logic [SW-1:0] b_mem [KDEPTH];

   // Slot write, plus zeroing of the unused tail on an early close
   always_ff @(posedge clk) begin
      for (int j = 0; j < KDEPTH; j++) begin
         if (wr_en) begin
            if (KW'(j) == wr_idx) begin
               a_mem[j] <= wr_a;
               b_mem[j] <= wr_b;
            end else if (zero_fill && (KW'(j) > wr_idx)) begin
               a_mem[j] <= '0;
               b_mem[j] <= '0;
            end
         end
      end
   end

   assign rd_a = a_mem[rd_idx];
   assign rd_b = b_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/tc_operand_stager.sv
`default_nettype none
// ============================================================================
//  Module   : tc_operand_stager
//  Purpose  : Collects A/B k-slices from warp lanes into a ping-pong pair of
//             tile banks and replays each complete tile as a gap-free
//             KDEPTH-cycle burst into the tensor core.
//  Options  : TC_STAGER_STATS_EN adds tiles_issued / starve_cycles counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tc_operand_stager
   import tc_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int SIZE   = DEF_SIZE,
   parameter int KDEPTH = DEF_KDEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SIZE*WIDTH-1:0]  in_a,
   input  logic [SIZE*WIDTH-1:0]  in_b,
   input  logic                   in_last,
   input  logic                   issue_en,
   output logic [SIZE*WIDTH-1:0]  tc_a_left,
   output logic [SIZE*WIDTH-1:0]  tc_b_top,
   output logic                   tc_valid,
   output logic                   tile_done,
   output logic                   err_len
`ifdef TC_STAGER_STATS_EN
   ,
   output logic [31:0]            tiles_issued,
   output logic [31:0]            starve_cycles
`endif
);

   localparam int            SW   = SIZE * WIDTH;
   localparam int            KW   = $clog2(KDEPTH);
   localparam logic [KW-1:0] LAST = KW'(KDEPTH - 1);

   // ---------------------------------------------------------------- write side
   logic [1:0]    full;
   logic          wr_bank;
   logic [KW-1:0] wk;
   logic          accept;
   logic          close;
   logic          early_last;
   logic          missing_last;

   // Ready depends only on registered flags, so a freed bank opens next cycle
   assign in_ready     = ~rst & ~full[wr_bank];
   assign accept       = in_valid & in_ready;
   assign early_last   = in_last & (wk != LAST);
   assign missing_last = ~in_last & (wk == LAST);
   assign close        = accept & (in_last | (wk == LAST));

   // Write slot pointer, bank toggle on close, sticky length error
   always_ff @(posedge clk) begin
      if (rst) begin
         wk      <= '0;
         wr_bank <= 1'b0;
         err_len <= 1'b0;
      end else if (accept) begin
         if (close) begin
            wk      <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wk <= wk + 1'b1;
         end
         if (early_last | missing_last) begin
            err_len <= 1'b1;
         end
      end
   end

   // ----------------------------------------------------------------- banks
   logic [SW-1:0] bank_a [2];
   logic [SW-1:0] bank_b [2];
   logic [KW-1:0] rd_idx;

   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         tc_tile_buf #(
            .WIDTH  (WIDTH),
            .SIZE   (SIZE),
            .KDEPTH (KDEPTH)
         ) u_buf (
            .clk       (clk),
            .wr_en     (accept && (wr_bank == 1'(b))),
            .wr_idx    (wk),
            .wr_a      (in_a),
            .wr_b      (in_b),
            .zero_fill (early_last),
            .rd_idx    (rd_idx),
            .rd_a      (bank_a[b]),
            .rd_b      (bank_b[b])
         );
      end
   endgenerate

   // --------------------------------------------------------------- read FSM
   stager_state_e state;
   stager_state_e state_nx;
   logic          rd_bank;
   logic [KW-1:0] rk;
   logic          launch;
   logic          step;
   logic          load0;
   logic          valid_nx;
   logic          done_nx;
   logic [KW-1:0] rk_nx;
   logic [SW-1:0] a_nx;
   logic [SW-1:0] b_nx;

   // In ISSUE, rk==0 marks the decision cycle right after a tile's last slice
   assign launch = full[rd_bank] & issue_en;
   assign step   = (state == ISSUE) && (rk != '0);
   assign load0  = ~step & launch;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state: stay in ISSUE while a tile is mid-burst or another starts
   always_comb begin
      state_nx = IDLE;
      if (step || load0) begin
         state_nx = ISSUE;
      end
   end

   // Output and datapath next values for the registered core interface
   always_comb begin
      rd_idx   = step ? rk : '0;
      valid_nx = step | load0;
      done_nx  = step & (rk == LAST);
      rk_nx    = '0;
      if (load0) begin
         rk_nx = KW'(1);
      end else if (step && (rk != LAST)) begin
         rk_nx = rk + 1'b1;
      end
      a_nx = valid_nx ? bank_a[rd_bank] : '0;
      b_nx = valid_nx ? bank_b[rd_bank] : '0;
   end

   // Registered core-facing outputs and read pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         rk        <= '0;
         rd_bank   <= 1'b0;
         tc_valid  <= 1'b0;
         tile_done <= 1'b0;
         tc_a_left <= '0;
         tc_b_top  <= '0;
      end else begin
         rk        <= rk_nx;
         rd_bank   <= rd_bank ^ done_nx;
         tc_valid  <= valid_nx;
         tile_done <= done_nx;
         tc_a_left <= a_nx;
         tc_b_top  <= b_nx;
      end
   end

   // Bank full flags: set on write-side close, cleared as the last slice issues
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (close && (wr_bank == 1'(b))) begin
               full[b] <= 1'b1;
            end else if (done_nx && (rd_bank == 1'(b))) begin
               full[b] <= 1'b0;
            end
         end
      end
   end

`ifdef TC_STAGER_STATS_EN
   // Tile counter (wrapping) and starvation counter (saturating)
   always_ff @(posedge clk) begin
      if (rst) begin
         tiles_issued  <= '0;
         starve_cycles <= '0;
      end else begin
         if (tile_done) begin
            tiles_issued <= tiles_issued + 32'd1;
         end
         if ((state == IDLE) && issue_en && !full[rd_bank] && !(&starve_cycles)) begin
            starve_cycles <= starve_cycles + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tc_operand_stager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tc_operand_stager
//  Purpose  : Directed self-checking bench for tc_operand_stager.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tc_operand_stager;
   import tc_pkg::*;

   localparam int W = DEF_WIDTH;
   localparam int S = DEF_SIZE;
   localparam int K = DEF_KDEPTH;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   in_valid = 1'b0;
   logic   in_ready;
   slice_t in_a = '0;
   slice_t in_b = '0;
   logic   in_last = 1'b0;
   logic   issue_en = 1'b0;
   slice_t tc_a_left;
   slice_t tc_b_top;
   logic   tc_valid;
   logic   tile_done;
   logic   err_len;
`ifdef TC_STAGER_STATS_EN
   logic [31:0] tiles_issued;
   logic [31:0] starve_cycles;
`endif

   tc_operand_stager dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .issue_en  (issue_en),
      .tc_a_left (tc_a_left),
      .tc_b_top  (tc_b_top),
      .tc_valid  (tc_valid),
      .tile_done (tile_done),
      .err_len   (err_len)
`ifdef TC_STAGER_STATS_EN
      ,
      .tiles_issued  (tiles_issued),
      .starve_cycles (starve_cycles)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every valid core beat
   slice_t q_a[$];
   slice_t q_b[$];
   logic   q_done[$];
   int     q_cyc[$];
   always @(negedge clk) begin
      if (tc_valid) begin
         q_a.push_back(tc_a_left);
         q_b.push_back(tc_b_top);
         q_done.push_back(tile_done);
         q_cyc.push_back(cyc);
      end
   end

   slice_t ex_a[$];
   slice_t ex_b[$];

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_q();
      q_a.delete(); q_b.delete(); q_done.delete(); q_cyc.delete();
      ex_a.delete(); ex_b.delete();
   endtask

   function automatic slice_t fill(input logic [15:0] v);
      return {S{v}};
   endfunction

   function automatic slice_t unit_vec(input int k);
      slice_t s;
      s = '0;
      s[k*W +: W] = 16'd1;
      return s;
   endfunction

   task automatic send(input slice_t a, input slice_t b, input logic last, output int edge_idx);
      int n;
      n = 0;
      in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
      while (!in_ready && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) check("send_timeout", 128'd0, 128'd1);
      tick();
      edge_idx = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic cmp_q(input string tag);
      check($sformatf("%s_count", tag), 128'(q_a.size()), 128'(ex_a.size()));
      for (int i = 0; i < ex_a.size() && i < q_a.size(); i++) begin
         check($sformatf("%s_a%0d", tag, i), q_a[i], ex_a[i]);
         check($sformatf("%s_b%0d", tag, i), q_b[i], ex_b[i]);
         check($sformatf("%s_done%0d", tag, i), 128'(q_done[i]), 128'((i % K) == K - 1));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int e;
      int n;

      // Reset state
      tick(); tick();
      check("rst_in_ready",  128'(in_ready), 128'd0);
      check("rst_tc_valid",  128'(tc_valid), 128'd0);
      check("rst_a_left",    tc_a_left, 128'd0);
      check("rst_b_top",     tc_b_top, 128'd0);
      check("rst_tile_done", 128'(tile_done), 128'd0);
      check("rst_err_len",   128'(err_len), 128'd0);
      rst = 1'b0;
      tick();
      check("post_rst_ready", 128'(in_ready), 128'd1);

      // Identity tile
      issue_en = 1'b1;
      clear_q();
      for (int k = 0; k < K; k++) begin
         send(unit_vec(k), unit_vec(k), k == K - 1, e);
         ex_a.push_back(unit_vec(k));
         ex_b.push_back(unit_vec(k));
      end
      repeat (8) tick();
      cmp_q("ident");
      if (q_cyc.size() > 0) check("ident_latency", 128'(q_cyc[0]), 128'(e + 1));
      check("ident_err", 128'(err_len), 128'd0);

      // Two tiles streamed continuously
      clear_q();
      for (int t = 0; t < 2 * K; t++) begin
         send(fill(16'(t + 1)), fill(16'(t + 101)), (t % K) == K - 1, e);
         ex_a.push_back(fill(16'(t + 1)));
         ex_b.push_back(fill(16'(t + 101)));
      end
      repeat (12) tick();
      cmp_q("stream");
      if (q_cyc.size() == 2 * K) check("stream_gapless", 128'(q_cyc[2*K-1] - q_cyc[0]), 128'(2 * K - 1));

      // Back-pressure with issue held off
      issue_en = 1'b0;
      clear_q();
      for (int t = 0; t < 2 * K; t++) begin
         send(fill(16'(t + 21)), fill(16'(t + 221)), (t % K) == K - 1, e);
         ex_a.push_back(fill(16'(t + 21)));
         ex_b.push_back(fill(16'(t + 221)));
      end
      in_a = fill(16'd29); in_b = fill(16'd229); in_valid = 1'b1;
      repeat (4) tick();
      check("bp_ready_low", 128'(in_ready), 128'd0);
      check("bp_no_issue",  128'(q_a.size()), 128'd0);
      issue_en = 1'b1;
      for (int t = 0; t < K; t++) begin
         send(fill(16'(t + 29)), fill(16'(t + 229)), t == K - 1, e);
         ex_a.push_back(fill(16'(t + 29)));
         ex_b.push_back(fill(16'(t + 229)));
      end
      repeat (16) tick();
      cmp_q("bp");

      // Early in_last: zero-filled tail, sticky error
      do_reset();
      clear_q();
      send(fill(16'h000A), fill(16'h00A0), 1'b0, e);
      send(fill(16'h000B), fill(16'h00B0), 1'b1, e);
      ex_a.push_back(fill(16'h000A)); ex_b.push_back(fill(16'h00A0));
      ex_a.push_back(fill(16'h000B)); ex_b.push_back(fill(16'h00B0));
      ex_a.push_back('0); ex_b.push_back('0);
      ex_a.push_back('0); ex_b.push_back('0);
      repeat (8) tick();
      cmp_q("short");
      check("short_err", 128'(err_len), 128'd1);
      for (int t = 0; t < K; t++) send(fill(16'(t + 41)), fill(16'(t + 41)), t == K - 1, e);
      repeat (8) tick();
      check("short_err_sticky", 128'(err_len), 128'd1);

      // Missing in_last: forced close, fifth beat starts next tile
      do_reset();
      clear_q();
      for (int t = 0; t < 5; t++) begin
         send(fill(16'(t + 1)), fill(16'(t + 51)), 1'b0, e);
      end
      tick();
      check("nolast_err", 128'(err_len), 128'd1);
      for (int t = 5; t < 8; t++) begin
         send(fill(16'(t + 1)), fill(16'(t + 51)), t == 7, e);
      end
      for (int t = 0; t < 8; t++) begin
         ex_a.push_back(fill(16'(t + 1)));
         ex_b.push_back(fill(16'(t + 51)));
      end
      repeat (10) tick();
      cmp_q("nolast");

      // Reset mid-burst
      do_reset();
      check("rst_clears_err", 128'(err_len), 128'd0);
`ifdef TC_STAGER_STATS_EN
      check("rst_tiles_issued", tiles_issued, 128'd0);
`endif
      clear_q();
      for (int k = 0; k < K; k++) send(unit_vec(k), unit_vec(k), k == K - 1, e);
      n = 0;
      while (q_a.size() < 2 && n < 20) begin
         tick();
         n++;
      end
      check("midrst_reached", 128'(q_a.size()), 128'd2);
      rst = 1'b1;
      tick();
      check("midrst_valid",  128'(tc_valid), 128'd0);
      check("midrst_done",   128'(tile_done), 128'd0);
      check("midrst_ready",  128'(in_ready), 128'd0);
      rst = 1'b0;
      tick();
      check("midrst_ready_after", 128'(in_ready), 128'd1);
      repeat (10) tick();
      check("midrst_no_residual", 128'(q_a.size()), 128'd2);
      check("midrst_a_zero", tc_a_left, 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
